// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer and its ALU port mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ALU opcode encodings, MD_* operation encodings, sequencer state enum.
package muldiv_seq_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = $clog2(MD_XLEN);

    // Shared ALU opcodes; the sequencer only ever issues ALU_ADD and ALU_SUB.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    // op[1] set means a divide-class operation.
    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Handshake/operand bundle between the pipeline, the shared ALU and muldiv_seq.
// Latency: wires only.
// Backpressure: busy stalls the pipeline; start is dropped while busy.
// master = pipeline/datapath side, slave = muldiv_seq.
interface muldiv_seq_if
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = MD_XLEN
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;

    modport master (
        output start, op, src_a, src_b, flush, alu_result,
        input  busy, done, result, alu_sel, alu_a, alu_b
    );

    modport slave (
        input  start, op, src_a, src_b, flush, alu_result,
        output busy, done, result, alu_sel, alu_a, alu_b
    );
endinterface

// File: rtl/muldiv_seq_alu_port_mux.sv
// 2:1 steering of the shared ALU inputs between pipeline decode and muldiv_seq.
// Latency: combinational.
// Backpressure: none; busy_i simply hands the ALU to the sequencer.
// Ports: busy_i select; pipe_*_i decode path; md_*_i sequencer; alu_*_o to the ALU.
module alu_port_mux
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            busy_i,
    input  logic [3:0]      pipe_sel_i,
    input  logic [XLEN-1:0] pipe_a_i,
    input  logic [XLEN-1:0] pipe_b_i,
    input  logic [3:0]      md_sel_i,
    input  logic [XLEN-1:0] md_a_i,
    input  logic [XLEN-1:0] md_b_i,
    output logic [3:0]      alu_sel_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o
);
    assign alu_sel_o = busy_i ? md_sel_i : pipe_sel_i;
    assign alu_a_o   = busy_i ? md_a_i   : pipe_a_i;
    assign alu_b_o   = busy_i ? md_b_i   : pipe_b_i;
endmodule

// File: rtl/muldiv_seq.sv
// Unsigned MUL/MULHU/DIVU/REMU sequencer, one shared-ALU add/sub per cycle.
// Latency: XLEN CALC cycles, done XLEN+1 cycles after start; divide-by-zero done next cycle.
// Backpressure: busy stalls the pipeline; start during CALC is dropped, flush aborts.
// Ports: clk, rst (async, active-high); md (muldiv_seq_if.slave): start/op/src_a/src_b/flush
//        in, busy/done/result out, alu_sel/alu_a/alu_b out, alu_result in (same cycle).
// Optional: define MULDIV_EARLY_OUT_EN to finish trivial operands without CALC.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave md
);
    // Register roles are shared between the two algorithms:
    //   acc: hi (multiply)  / rem (divide)
    //   shf: lo (multiply)  / quo (divide)
    //   opn: mcand (multiply) / dvs (divide)
    md_state_t       state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] shf_q, shf_d;
    logic [XLEN-1:0] opn_q, opn_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN:0]   sh;
    logic            carry;
    logic            ge;
    logic            launch;
    logic            div_zero;
    logic            trivial;
    logic [XLEN-1:0] quick_res;

    // Divide step: shift the next dividend bit into the partial remainder.
    assign sh    = {acc_q, shf_q[XLEN-1]};
    // Multiply step: an unsigned add wrapped iff the sum is below an addend.
    assign carry = md.alu_result < acc_q;
    // sh is 33 bits; a set MSB already exceeds any 32-bit divisor.
    assign ge    = sh[XLEN] | (sh[XLEN-1:0] >= opn_q);

    assign launch   = (state_q != MD_CALC) && md.start && !md.flush;
    assign div_zero = md.op[1] && (md.src_b == '0);

`ifdef MULDIV_EARLY_OUT_EN
    assign trivial = md.op[1] ? ((md.src_b != '0) && (md.src_a < md.src_b))
                              : ((md.src_a == '0) || (md.src_b == '0));
`else
    assign trivial = 1'b0;
`endif

    // Result for operations that complete without iterating.
    always_comb begin
        quick_res = '0;
        case (md.op)
            MD_DIVU: quick_res = div_zero ? '1 : '0;
            MD_REMU: quick_res = md.src_a;
            default: quick_res = '0;
        endcase
    end

    // ALU drive is kept separate from next-state logic so the path
    // alu_a/alu_b -> external ALU -> alu_result never loops in one block.
    always_comb begin
        md.alu_sel = ALU_ADD;
        md.alu_a   = '0;
        md.alu_b   = '0;
        if (state_q == MD_CALC) begin
            if (op_q[1]) begin
                md.alu_sel = ALU_SUB;
                md.alu_a   = sh[XLEN-1:0];
                md.alu_b   = opn_q;
            end else begin
                md.alu_sel = ALU_ADD;
                md.alu_a   = acc_q;
                md.alu_b   = shf_q[0] ? opn_q : '0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        shf_d    = shf_q;
        opn_d    = opn_q;
        result_d = result_q;
        cnt_d    = cnt_q;

        case (state_q)
            MD_IDLE, MD_DONE: begin
                state_d = MD_IDLE;
                if (launch) begin
                    op_d  = md.op;
                    cnt_d = '0;
                    acc_d = '0;
                    if (md.op[1]) begin
                        shf_d = md.src_a;
                        opn_d = md.src_b;
                    end else begin
                        shf_d = md.src_b;
                        opn_d = md.src_a;
                    end
                    if (div_zero || trivial) begin
                        state_d  = MD_DONE;
                        result_d = quick_res;
                    end else begin
                        state_d = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (md.flush) begin
                    state_d = MD_IDLE;
                end else begin
                    if (op_q[1]) begin
                        acc_d = ge ? md.alu_result : sh[XLEN-1:0];
                        shf_d = {shf_q[XLEN-2:0], ge};
                    end else begin
                        // {hi,lo} <= {carry, sum, lo[XLEN-1:1]}
                        acc_d = {carry, md.alu_result[XLEN-1:1]};
                        shf_d = {md.alu_result[0], shf_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = MD_DONE;
                        case (op_q)
                            MD_MUL:   result_d = shf_d;
                            MD_MULHU: result_d = acc_d;
                            MD_DIVU:  result_d = shf_d;
                            default:  result_d = acc_d;
                        endcase
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            shf_q    <= '0;
            opn_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            shf_q    <= shf_d;
            opn_q    <= opn_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign md.busy   = (state_q == MD_CALC);
    assign md.done   = (state_q == MD_DONE);
    assign md.result = result_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle unsigned multiply/divide sequencer for the M-extension subset.
- Borrows the shared 32-bit ALU for the add/subtract step of each iteration: one ALU operation per cycle, 32 iterations.
- While busy, owns the ALU inputs through alu_port_mux and stalls the pipeline.
- Returns a 32-bit result with a single-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- CNT_W, 5, iteration counter width, $clog2(XLEN).

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  launch request; accepted only in IDLE or DONE
- op  in  2  MD_MUL=00 (low product), MD_MULHU=01 (high product), MD_DIVU=10, MD_REMU=11
- src_a  in  XLEN  multiplicand / dividend
- src_b  in  XLEN  multiplier / divisor
- flush  in  1  abort the operation in flight
- busy  out  1  high in CALC; pipeline stalls and ALU mux selects the sequencer
- done  out  1  one-cycle pulse in DONE
- result  out  XLEN  final value; held until the next accepted start
- alu_sel  out  4  ALU opcode driven to the shared ALU
- alu_a  out  XLEN  ALU operand A
- alu_b  out  XLEN  ALU operand B
- alu_result  in  XLEN  combinational ALU output, same cycle

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; busy=0, done=0, result=0.
  - alu_sel=ALU_ADD, alu_a=0, alu_b=0; all internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE/DONE, start=1, flush=0:
  - Latch op, src_a, src_b; counter cnt=0.
  - Divisor==0 with DIVU/REMU: go to DONE next cycle. Result 0xFFFFFFFF for DIVU, src_a for REMU.
  - Otherwise go to CALC.
- Multiply registers: hi=0, lo=src_b, mcand=src_a.
  - Each CALC cycle: alu_sel=ALU_ADD, alu_a=hi, alu_b = lo[0] ? mcand : 0.
  - carry = (alu_result < hi), unsigned compare.
  - Update {hi,lo} <= {carry, alu_result, lo[31:1]}.
- Divide registers: rem=0, quo=src_a, dvs=src_b.
  - Each CALC cycle: sh={rem, quo[31]} (33 bits); alu_sel=ALU_SUB, alu_a=sh[31:0], alu_b=dvs.
  - ge = sh[32] | (sh[31:0] >= dvs).
  - Update rem <= ge ? alu_result : sh[31:0]; quo <= {quo[30:0], ge}.
- CALC: cnt increments each cycle; when cnt==31, go to DONE and load result:
  - MUL: lo
  - MULHU: hi
  - DIVU: quo
  - REMU: rem
- DONE: done=1 for exactly one cycle, busy=0.
  - Next state is IDLE, or CALC/DONE if a new start is accepted.
- Latency: start at cycle 0 → busy cycles 1–32 → done at cycle 33. Divide-by-zero: done at cycle 1.
- ALU outputs are don't-care outside CALC but are driven to stable values: ALU_ADD, 0, 0.
- start while in CALC: ignored, no queuing.
- flush:
  - Any state → IDLE next cycle; done is not asserted for the aborted operation; result is unchanged.
  - flush has priority over a simultaneous start.
- rst mid-CALC: immediate return to reset values; no done pulse.
- Operand ports are sampled only at start; changes during CALC have no effect.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: trivial operands complete in DONE at cycle 1 with no CALC.
  - MUL/MULHU with src_a==0 or src_b==0: result 0.
  - DIVU/REMU with src_b!=0 and src_a<src_b (unsigned): DIVU result 0, REMU result src_a.
- Undefined: these cases take the full 33-cycle path. Results are identical either way.

Decomposition:
- Shared definitions header:
  - ALU_* opcode encodings (ALU_ADD, ALU_SUB are reused as-is).
  - New MD_MUL/MD_MULHU/MD_DIVU/MD_REMU encodings.
  - MD state enum constants.
- Sub-module alu_port_mux: 2:1 selection of alu_sel/dataA/dataB between the pipeline decode path and muldiv_seq, steered by busy. Purely combinational, instantiated at the datapath top, not inside muldiv_seq.

Test Plan:
- MUL 7×6: start cycle 0 → busy cycles 1–32, done at cycle 33, result=0x0000002A; alu_sel=ALU_ADD throughout CALC.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFE; MUL same operands → 0x00000001.
- DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002; DIVU 0x80000000/1 → 0x80000000; alu_sel=ALU_SUB during CALC.
- Divide by zero: DIVU 5/0 → done at cycle 1, 0xFFFFFFFF; REMU 5/0 → 0x00000005; busy never asserted.
- flush at cycle 10 of a DIVU → busy=0 at cycle 11, no done, result keeps its previous value; start at cycle 9 during CALC ignored.
- rst asserted asynchronously mid-CALC → all outputs zero immediately; a subsequent MUL 3×5 → 0x0000000F. With MULDIV_EARLY_OUT_EN: MUL 0×9 and DIVU 3/8 → done at cycle 1, result 0.
